// File: rtl/pwm_duty_meter_pkg.sv
// Shared definitions for the PWM duty meter.
//   PCT_FULL  : full-scale duty in percent
//   CNT_W_DEF : default width of the period / high-time counters
//   state_e   : measurement FSM states
package pwm_duty_meter_pkg;

  localparam int unsigned PCT_FULL  = 100;
  localparam int unsigned CNT_W_DEF = 24;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DIVIDE  = 2'd3
  } state_e;

endpackage

// File: rtl/pwm_duty_meter_div.sv
// Sequential restoring divider, one quotient bit per clock.
//   clk, rstp : clock, synchronous active-high reset
//   start     : load num/den and begin (ignored while abort is high)
//   abort     : drop any division in progress, no done pulse
//   num, den  : dividend (NUM_W bits), divisor (DEN_W bits, must be non-zero)
//   quo       : quotient, valid while done is high and held afterwards
//   done      : one-cycle pulse, NUM_W+1 cycles after the start cycle
module pwm_duty_meter_div #(
  parameter int unsigned NUM_W = 31,
  parameter int unsigned DEN_W = 24
) (
  input  logic             clk,
  input  logic             rstp,
  input  logic             start,
  input  logic             abort,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic [NUM_W-1:0] quo,
  output logic             done
);

  localparam int unsigned IT_W = $clog2(NUM_W + 1);

  logic [DEN_W-1:0] rem_q, rem_d;
  logic [NUM_W-1:0] quo_q, quo_d;
  logic [DEN_W-1:0] den_q, den_d;
  logic [IT_W-1:0]  cnt_q, cnt_d;
  logic             run_q, run_d;
  logic             done_q, done_d;
  logic [DEN_W:0]   trial;
  logic [DEN_W:0]   diff;
  logic             ge;

  always_comb begin
    // quo_q shifts the dividend out of its top while quotient bits enter at the bottom
    trial = {rem_q, quo_q[NUM_W-1]};
    diff  = trial - {1'b0, den_q};
    // rem < den keeps trial < 2*den, so the top bit of diff is a clean borrow flag
    ge    = ~diff[DEN_W];

    rem_d  = rem_q;
    quo_d  = quo_q;
    den_d  = den_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = 1'b0;

    if (abort) begin
      run_d = 1'b0;
    end else if (start) begin
      rem_d = '0;
      quo_d = num;
      den_d = den;
      cnt_d = IT_W'(NUM_W);
      run_d = 1'b1;
    end else if (run_q) begin
      rem_d = ge ? diff[DEN_W-1:0] : trial[DEN_W-1:0];
      quo_d = {quo_q[NUM_W-2:0], ge};
      cnt_d = cnt_q - IT_W'(1);
      if (cnt_q == IT_W'(1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstp) begin
      rem_q  <= '0;
      quo_q  <= '0;
      den_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      den_q  <= den_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign quo  = quo_q;
  assign done = done_q;

endmodule

// File: rtl/pwm_duty_meter.sv
// PWM duty-cycle meter: measures rise-to-rise period and high time of an
// asynchronous PWM input and reports duty in integer percent (floor).
//   clk, rstp  : system clock, synchronous active-high reset
//   pwm_in     : asynchronous PWM input
//   duty       : last measured duty, 0..100 percent
//   duty_valid : one-cycle pulse when duty/period update
//   period     : last measured period in clk cycles
//   busy       : divider running
//   overrun    : one-cycle pulse when a completed period is dropped
//   no_signal  : high while the input is static (timeout reached)
module pwm_duty_meter
  import pwm_duty_meter_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned TIMEOUT_CYC = 2500000,
  parameter int unsigned NUM_W       = CNT_W + 7
) (
  input  logic             clk,
  input  logic             rstp,
  input  logic             pwm_in,
  output logic [7:0]       duty,
  output logic             duty_valid,
  output logic [CNT_W-1:0] period,
  output logic             busy,
  output logic             overrun,
  output logic             no_signal
);

  logic             sync_meta_q, sync_meta_d;
  logic             pwm_s_q, pwm_s_d;
  logic             pwm_prev_q, pwm_prev_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0] den_q, den_d;
  state_e           state_q, state_d;
  logic [7:0]       duty_q, duty_d;
  logic             duty_valid_q, duty_valid_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;
  logic             no_signal_q, no_signal_d;

  logic             rise;
  logic             to_hit;
  logic             div_start;
  logic [NUM_W-1:0] high_ext;
  logic [NUM_W-1:0] num100;
  logic [NUM_W-1:0] div_quo;
  logic             div_done;

  pwm_duty_meter_div #(
    .NUM_W (NUM_W),
    .DEN_W (CNT_W)
  ) seq_divider_u (
    .clk   (clk),
    .rstp  (rstp),
    .start (div_start),
    .abort (to_hit),
    .num   (num100),
    .den   (period_cnt_q),
    .quo   (div_quo),
    .done  (div_done)
  );

  always_comb begin
    sync_meta_d = pwm_in;
    pwm_s_d     = sync_meta_q;
    pwm_prev_d  = pwm_s_q;
    rise        = pwm_s_q & ~pwm_prev_q;

    // high*100 = high*64 + high*32 + high*4
    high_ext = NUM_W'(high_cnt_q);
    num100   = (high_ext << 6) + (high_ext << 5) + (high_ext << 2);

    // The counter saturates past TIMEOUT_CYC, so equality fires once per static
    // stretch; no_signal stops a repeat while idle after a timeout.
    to_hit = (period_cnt_q == CNT_W'(TIMEOUT_CYC)) && !rise &&
             ((state_q != ST_IDLE) || !no_signal_q);

    if (rise) begin
      period_cnt_d = CNT_W'(1);
      high_cnt_d   = CNT_W'(1);
    end else begin
      period_cnt_d = (period_cnt_q == '1) ? period_cnt_q : period_cnt_q + CNT_W'(1);
      high_cnt_d   = (pwm_s_q && high_cnt_q != '1) ? high_cnt_q + CNT_W'(1) : high_cnt_q;
    end

    div_start    = 1'b0;
    state_d      = state_q;
    den_d        = den_q;
    duty_d       = duty_q;
    duty_valid_d = 1'b0;
    period_d     = period_q;
    overrun_d    = 1'b0;
    no_signal_d  = no_signal_q;

    if (to_hit) begin
      duty_d       = pwm_s_q ? 8'(PCT_FULL) : '0;
      duty_valid_d = 1'b1;
      no_signal_d  = 1'b1;
      state_d      = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            state_d     = ST_ARMED;
            no_signal_d = 1'b0;
          end
        end
        ST_ARMED, ST_MEASURE: begin
          if (rise) begin
            div_start = 1'b1;
            den_d     = period_cnt_q;
            state_d   = ST_DIVIDE;
          end
        end
        ST_DIVIDE: begin
          if (rise) overrun_d = 1'b1;
          if (div_done) begin
            duty_d       = (div_quo > NUM_W'(PCT_FULL)) ? 8'(PCT_FULL) : div_quo[7:0];
            period_d     = den_q;
            duty_valid_d = 1'b1;
            state_d      = ST_MEASURE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d == ST_DIVIDE);
  end

  always_ff @(posedge clk) begin
    if (rstp) begin
      sync_meta_q  <= 1'b0;
      pwm_s_q      <= 1'b0;
      pwm_prev_q   <= 1'b0;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      den_q        <= '0;
      state_q      <= ST_IDLE;
      duty_q       <= '0;
      duty_valid_q <= 1'b0;
      period_q     <= '0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      no_signal_q  <= 1'b0;
    end else begin
      sync_meta_q  <= sync_meta_d;
      pwm_s_q      <= pwm_s_d;
      pwm_prev_q   <= pwm_prev_d;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      den_q        <= den_d;
      state_q      <= state_d;
      duty_q       <= duty_d;
      duty_valid_q <= duty_valid_d;
      period_q     <= period_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      no_signal_q  <= no_signal_d;
    end
  end

  assign duty       = duty_q;
  assign duty_valid = duty_valid_q;
  assign period     = period_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;
  assign no_signal  = no_signal_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Scoreboard bench for pwm_duty_meter: stimulus pushes expected results,
// a negedge monitor pops and compares on every duty_valid pulse.
module tb_pwm_duty_meter;

  localparam int unsigned CNT_W = 24;
  localparam int unsigned NUM_W = CNT_W + 7;
  localparam int unsigned TO    = 3000;

  logic             clk = 1'b0;
  logic             rstp = 1'b1;
  logic             pwm_in = 1'b0;
  logic [7:0]       duty;
  logic             duty_valid;
  logic [CNT_W-1:0] period;
  logic             busy;
  logic             overrun;
  logic             no_signal;

  pwm_duty_meter #(
    .CNT_W       (CNT_W),
    .TIMEOUT_CYC (TO),
    .NUM_W       (NUM_W)
  ) dut (
    .clk        (clk),
    .rstp       (rstp),
    .pwm_in     (pwm_in),
    .duty       (duty),
    .duty_valid (duty_valid),
    .period     (period),
    .busy       (busy),
    .overrun    (overrun),
    .no_signal  (no_signal)
  );

  always #4 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int duty;
    int period;
    int at;   // expected cyc of the valid pulse, -1 = not checked
    bit to;   // timeout result, no_signal must be high
    int cmd;  // commanded duty for the +-1 check, -1 = none
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int ov_seen = 0;
  int ov_exp = 0;

  bit armed = 1'b0;
  int last_acc = -1;
  int prev_p = 1;
  int prev_h = 0;
  int prev_cmd = -1;

  function automatic void chk(string name, int act, int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d (cyc %0d)", name, act, expv, cyc);
    end
  endfunction

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (overrun) ov_seen++;
    if (duty_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid got duty=%0d period=%0d want no valid (cyc %0d)",
                 duty, period, cyc);
      end else begin
        e = sb.pop_front();
        chk("duty", int'(duty), e.duty);
        chk("period", int'(period), e.period);
        if (e.at >= 0) chk("latency", cyc, e.at);
        if (e.to) chk("no_signal_on_timeout", int'(no_signal), 1);
        if (e.cmd >= 0) begin
          int dif;
          dif = int'(duty) - e.cmd;
          chk("duty_within_1", int'(dif >= -1 && dif <= 1), 1);
        end
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model of what a rising edge (driven now) should produce
  task automatic note_rise();
    exp_t e;
    int d;
    if (!armed) begin
      armed = 1'b1;
    end else if (last_acc >= 0 && (cyc - last_acc) <= int'(NUM_W) + 1) begin
      ov_exp++;
    end else begin
      d = (prev_h * 100) / prev_p;
      if (d > 100) d = 100;
      e.duty = d;
      e.period = prev_p;
      e.at = cyc + int'(NUM_W) + 4;
      e.to = 1'b0;
      e.cmd = prev_cmd;
      sb.push_back(e);
      last_acc = cyc;
    end
  endtask

  task automatic wave(int p, int h, int cmd);
    pwm_in = 1'b1;
    note_rise();
    prev_p = p;
    prev_h = h;
    prev_cmd = cmd;
    step(h);
    pwm_in = 1'b0;
    step(p - h);
  endtask

  task automatic close_rise();
    pwm_in = 1'b1;
    note_rise();
    step(int'(NUM_W) + 10);
  endtask

  task automatic do_reset();
    pwm_in = 1'b0;
    step(4);
    rstp = 1'b1;
    step(2);
    rstp = 1'b0;
    armed = 1'b0;
    last_acc = -1;
  endtask

  task automatic push_timeout(int d, int p);
    exp_t e;
    e.duty = d;
    e.period = p;
    e.at = -1;
    e.to = 1'b1;
    e.cmd = -1;
    sb.push_back(e);
  endtask

  initial begin
    int sweep [5] = '{11, 37, 50, 73, 99};

    step(3);
    rstp = 1'b0;
    @(negedge clk);
    chk("reset_duty", int'(duty), 0);
    chk("reset_period", int'(period), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_no_signal", int'(no_signal), 0);
    chk("reset_valid", int'(duty_valid), 0);
    chk("reset_overrun", int'(overrun), 0);
    step(1);

    // 1000-cycle period, 250 high
    do_reset();
    repeat (3) wave(1000, 250, -1);
    close_rise();

    // period 300: 100 high, then 299 high
    do_reset();
    repeat (2) wave(300, 100, -1);
    close_rise();
    do_reset();
    repeat (2) wave(300, 299, -1);
    close_rise();

    // stuck high after a measurement -> timeout reports 100
    do_reset();
    wave(300, 100, -1);
    pwm_in = 1'b1;
    note_rise();
    push_timeout(100, 300);
    armed = 1'b0;
    step(TO + 20);
    @(negedge clk);
    chk("stuck_high_no_signal", int'(no_signal), 1);
    chk("stuck_high_overrun_count", ov_seen, ov_exp);
    step(1);

    // held low from reset -> timeout reports 0, then a rise clears no_signal
    do_reset();
    push_timeout(0, 0);
    step(TO + 10);
    @(negedge clk);
    chk("stuck_low_no_signal", int'(no_signal), 1);
    chk("stuck_low_overrun_count", ov_seen, ov_exp);
    step(1);
    pwm_in = 1'b1;
    note_rise();
    step(5);
    @(negedge clk);
    chk("rise_clears_no_signal", int'(no_signal), 0);
    step(1);
    pwm_in = 1'b0;
    step(int'(NUM_W) + 10);

    // period shorter than the divide -> alternate edges overrun
    do_reset();
    repeat (8) wave(20, 7, -1);
    close_rise();
    chk("short_period_overrun_count", ov_seen, ov_exp);

    // reset in the middle of a divide
    do_reset();
    repeat (2) wave(1000, 250, -1);
    pwm_in = 1'b1;
    note_rise();
    step(5);
    pwm_in = 1'b0;
    step(10);
    @(negedge clk);
    chk("mid_divide_busy", int'(busy), 1);
    void'(sb.pop_back());
    @(posedge clk);
    #1;
    rstp = 1'b1;
    step(1);
    rstp = 1'b0;
    armed = 1'b0;
    last_acc = -1;
    @(negedge clk);
    chk("abort_duty", int'(duty), 0);
    chk("abort_period", int'(period), 0);
    chk("abort_busy", int'(busy), 0);
    step(int'(NUM_W) + 10);
    wave(400, 100, -1);
    close_rise();

    // duty sweep on a 1250-cycle period
    do_reset();
    foreach (sweep[i]) wave(1250, (sweep[i] * 1250) / 100, sweep[i]);
    close_rise();

    step(10);
    chk("scoreboard_drained", sb.size(), 0);
    chk("final_overrun_count", ov_seen, ov_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog timeout (cyc %0d)", cyc);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

endmodule
